test_monitor: RTL
=================

TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 Parameter CNT_W, default 32: width of the cycle and instruction counters.
REQ-002 Parameter TOHOST_PC, default 32'h00000086: PC value that marks the write-tohost instruction.
REQ-003 Parameter HIT_THRESH, default 8: number of tohost hits required to end the test; legal range 1..255.
REQ-004 Parameter IDX_W, default 10: signature word-index width.
REQ-005 Parameter TIMEOUT_CYC, default 50000: cycle limit, used only when the timeout feature is compiled in.
REQ-006 Ports, in order:
- clk  in  1  clock; one clock.
- cpurst  in  1  synchronous, active-high reset.
- inst_valid  in  1  instruction issued decode->execute.
- inst_pc  in  32  PC of the issued instruction.
- x3_val  in  32  architectural x3.
- mode  in  1  0 = x3 check, 1 = signature compare; sampled in RUN only.
- sig_base  in  32  byte address of the signature; word aligned.
- sig_len  in  IDX_W  number of signature words.
- rd_req  out  1  one-cycle read request.
- rd_addr  out  32  equals sig_base+4*idx.
- rd_idx  out  IDX_W  index into the reference memory.
- rd_valid  in  1  read response; latency 1 or more cycles.
- rd_data  in  32  DUT memory word.
- ref_data  in  32  reference word; valid with rd_valid.
- done  out  1  test finished; sticky.
- pass  out  1  result; valid when done=1.
- timeout  out  1  finished by timeout.
- fail_idx  out  IDX_W  index of the first mismatch.
- cycle_count  out  CNT_W  cycles since reset.
- inst_count  out  CNT_W  issued instructions.

Function
REQ-007 FSM states RUN, CMP, WAIT, DONE; RUN is entered on reset.
REQ-008 cycle_count increments by 1 every cycle in RUN, CMP and WAIT, freezes in DONE, and saturates at all-ones.
REQ-009 inst_count increments when inst_valid=1 in RUN, freezes otherwise, and saturates.
REQ-010 The 8-bit hit counter increments when inst_valid=1 and inst_pc==TOHOST_PC in RUN.
REQ-011 When the increment makes hits equal HIT_THRESH with mode=0, the next state is DONE and pass=(x3_val==1) sampled in that same cycle.
REQ-012 When the increment makes hits equal HIT_THRESH with mode=1, the next state is CMP with idx=0; if sig_len==0 the next state is DONE with pass=1 instead.
REQ-013 CMP: rd_req=1 for exactly one cycle with rd_addr/rd_idx for the current idx, then WAIT; at most one read is outstanding.
REQ-014 WAIT, on rd_valid: a mismatch (rd_data!=ref_data) -> DONE, pass=0, fail_idx=idx.
REQ-015 WAIT, on rd_valid: a match on the last word (idx==sig_len-1) -> DONE, pass=1.
REQ-016 WAIT, on rd_valid: a match on any other word -> idx+1, then CMP.
REQ-017 rd_valid outside WAIT is ignored.
REQ-018 In DONE, done=1 and all outputs hold their values until reset; rd_req=0.
REQ-019 rd_addr is computed modulo 2^32.

Reset
REQ-020 With cpurst=1 at a clock edge: state=RUN; hits, idx, counters=0; done, pass, timeout, rd_req=0; fail_idx=0; rd_addr=sig_base; rd_idx=0.
REQ-021 Reset asserted in any state, including WAIT with a read outstanding, aborts the test; a late rd_valid after reset is ignored.

Configuration
REQ-022 Macro TEST_MONITOR_TIMEOUT_EN: when defined, reaching cycle_count==TIMEOUT_CYC in RUN/CMP/WAIT -> DONE with timeout=1, pass=0.
REQ-023 If a threshold hit or compare completion occurs in the same cycle as the timeout, the threshold/compare result takes priority and timeout=0.
REQ-024 Without TEST_MONITOR_TIMEOUT_EN: timeout is tied to 0 and there is no timeout logic.

Verification
REQ-025 mode=0, 8 issues at PC 0x86 with x3=1 -> done one cycle after the 8th issue, pass=1, inst_count equals the issue count.
REQ-026 mode=0, 8 hits with x3=5 -> done=1, pass=0; 7 hits only -> done stays 0.
REQ-027 mode=1, sig_len=4, sig_base=0x2000, all words match, rd_valid latency 3 -> rd_addr 0x2000, 0x2004, 0x2008, 0x200C in order, then pass=1.
REQ-028 mode=1, sig_len=4, word 2 differs -> pass=0, fail_idx=2, and no read issued for idx 3.
REQ-029 TEST_MONITOR_TIMEOUT_EN, TIMEOUT_CYC=100, no hits -> done=1, timeout=1 at cycle_count=100; 8th hit in cycle 100 -> timeout=0.
REQ-030 cpurst pulse while in WAIT, followed by a stale rd_valid -> state=RUN, all outputs at reset values, stale response ignored.

Source files
------------

// File: rtl/test_monitor.sv
// ---------------------------------------------------------------------------
// test_monitor
//   Watches the core's issue stream and decides when a self-test program has
//   finished and whether it passed. Completion is signalled by the program
//   writing tohost (a fixed PC) HIT_THRESH times. The verdict comes either
//   from architectural x3 (mode=0) or from a word-by-word compare of a
//   signature region against a reference memory (mode=1).
//
// Optional feature:
//   TEST_MONITOR_TIMEOUT_EN - when defined, the test is ended with
//   timeout=1 once cycle_count reaches TIMEOUT_CYC; otherwise timeout is
//   tied to 0.
//
// Ports:
//   clk, cpurst      clock; synchronous active-high reset
//   inst_valid/_pc   issued instruction and its PC
//   x3_val           architectural x3, verdict in mode 0
//   mode             0 = x3 check, 1 = signature compare (sampled in RUN)
//   sig_base/sig_len signature byte address and length in words
//   rd_req/addr/idx  one-cycle signature read request
//   rd_valid/data    read response, ref_data is the matching reference word
//   done/pass        sticky finish flag and verdict
//   timeout          finished because the cycle limit was reached
//   fail_idx         index of the first mismatching signature word
//   cycle_count      cycles spent running since reset (saturating)
//   inst_count       instructions issued while running (saturating)
// ---------------------------------------------------------------------------
module test_monitor #(
  parameter int unsigned CNT_W       = 32,
  parameter logic [31:0] TOHOST_PC   = 32'h0000_0086,
  parameter int unsigned HIT_THRESH  = 8,
  parameter int unsigned IDX_W       = 10,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             cpurst,
  input  logic             inst_valid,
  input  logic [31:0]      inst_pc,
  input  logic [31:0]      x3_val,
  input  logic             mode,
  input  logic [31:0]      sig_base,
  input  logic [IDX_W-1:0] sig_len,
  output logic             rd_req,
  output logic [31:0]      rd_addr,
  output logic [IDX_W-1:0] rd_idx,
  input  logic             rd_valid,
  input  logic [31:0]      rd_data,
  input  logic [31:0]      ref_data,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [IDX_W-1:0] fail_idx,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count
);

  localparam int unsigned      HIT_W    = 8;
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HIT_THRESH);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Reject parameter values the hit counter and timeout compare cannot honour.
  if (HIT_THRESH < 1 || HIT_THRESH > 255 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("test_monitor: HIT_THRESH must be 1..255 and TIMEOUT_CYC at least 1");
  end

  logic [1:0]       state, state_next;
  logic [HIT_W-1:0] hits;
  logic [IDX_W-1:0] idx, idx_next;
  logic [IDX_W-1:0] fail_idx_next;
  logic             pass_next;
  logic             tohost_c, thresh_c, last_c, match_c;

  // Current issue is a tohost write, and it is the one that reaches the threshold.
  assign tohost_c = inst_valid && (inst_pc == TOHOST_PC);
  assign thresh_c = tohost_c && ((hits + HIT_W'(1)) == HIT_LAST);
  assign last_c   = (idx == (sig_len - IDX_W'(1)));
  assign match_c  = (rd_data == ref_data);

`ifdef TEST_MONITOR_TIMEOUT_EN
  // The comparison uses the pre-increment count so done and cycle_count==TIMEOUT_CYC coincide.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic tmo_c;
  logic timeout_next;
  assign tmo_c = (cycle_count >= TMO_LAST);
`endif

  // Next-state and result logic.
  always_comb begin : next_state
    state_next    = state;
    idx_next      = idx;
    pass_next     = pass;
    fail_idx_next = fail_idx;
`ifdef TEST_MONITOR_TIMEOUT_EN
    timeout_next  = timeout;
`endif
    case (state)
      ST_RUN: begin
        if (thresh_c) begin
          if (!mode) begin
            state_next = ST_DONE;
            pass_next  = (x3_val == 32'd1);
          end else if (sig_len == '0) begin
            state_next = ST_DONE;
            pass_next  = 1'b1;
          end else begin
            state_next = ST_CMP;
            idx_next   = '0;
          end
        end
      end
      ST_CMP: state_next = ST_WAIT;
      ST_WAIT: begin
        if (rd_valid) begin
          if (!match_c) begin
            state_next    = ST_DONE;
            pass_next     = 1'b0;
            fail_idx_next = idx;
          end else if (last_c) begin
            state_next = ST_DONE;
            pass_next  = 1'b1;
          end else begin
            state_next = ST_CMP;
            idx_next   = idx + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
`ifdef TEST_MONITOR_TIMEOUT_EN
    // A threshold hit or compare completion in the same cycle wins over the timeout.
    if (tmo_c && (state != ST_DONE) && (state_next != ST_DONE) &&
        !((state == ST_RUN) && thresh_c)) begin
      state_next   = ST_DONE;
      pass_next    = 1'b0;
      timeout_next = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin : state_reg
    if (cpurst) state <= ST_RUN;
    else        state <= state_next;
  end

  // Counters, verdict and read-request registers.
  always_ff @(posedge clk) begin : datapath
    if (cpurst) begin
      hits        <= '0;
      idx         <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_idx    <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= sig_base;
      rd_idx      <= '0;
    end else begin
      if ((state != ST_DONE) && (cycle_count != '1))
        cycle_count <= cycle_count + CNT_W'(1);
      if ((state == ST_RUN) && inst_valid && (inst_count != '1))
        inst_count <= inst_count + CNT_W'(1);
      if ((state == ST_RUN) && tohost_c)
        hits <= hits + HIT_W'(1);
      idx      <= idx_next;
      pass     <= pass_next;
      fail_idx <= fail_idx_next;
      done     <= (state_next == ST_DONE);
      // rd_req is high exactly while the FSM sits in CMP.
      rd_req   <= (state_next == ST_CMP);
      // Address tracks the index until the result is frozen; wraps modulo 2^32.
      if (state_next != ST_DONE) begin
        rd_idx  <= idx_next;
        rd_addr <= sig_base + (32'(idx_next) << 2);
      end
    end
  end

`ifdef TEST_MONITOR_TIMEOUT_EN
  // Timeout flag register.
  always_ff @(posedge clk) begin : timeout_reg
    if (cpurst) timeout <= 1'b0;
    else        timeout <= timeout_next;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
